// File: rtl/parity_serializer_if.sv
// parity_serializer_if: word handshake and serial-frame signals of the parity serializer
interface parity_serializer_if #(
  parameter int N = 8
);
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_is_par;
  logic         ser_last;
  logic         busy;
  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, ser_is_par, ser_last, busy
  );
  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, ser_is_par, ser_last, busy
  );
endinterface

// File: rtl/parity_serializer.sv
// parity_serializer: shifts an N-bit word out LSB-first, then one parity bit (N+1 cycles per frame)
module parity_serializer #(
  parameter int N   = 8,
  parameter bit ODD = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  parity_serializer_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;
  state_t        r_state, w_next;
  logic [N-1:0]  r_shreg;
  logic [CW-1:0] r_cnt;
  logic          r_acc;
  logic          w_ready, w_accept, w_last;
  // ready is held low while reset is asserted, even though IDLE is already forced
  assign w_ready  = rst_n && (r_state != DATA);
  assign w_accept = w_ready && bus.in_valid;
  assign w_last   = (r_cnt == CW'(N - 1));
  always_comb begin
    w_next = r_state;
    w_next = (r_state == DATA) ? (w_last ? PAR : DATA) : (bus.in_valid ? DATA : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_acc   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_shreg <= bus.in_data;
        r_cnt   <= '0;
        r_acc   <= 1'b0;
      end else if (r_state == DATA) begin
        r_shreg <= r_shreg >> 1;
        r_acc   <= r_acc ^ r_shreg[0];
        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end
  assign bus.in_ready   = w_ready;
  assign bus.ser_valid  = (r_state != IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.ser_is_par = (r_state == PAR);
  assign bus.ser_last   = (r_state == PAR);
  assign bus.ser_out    = (r_state == DATA) ? r_shreg[0] : ((r_state == PAR) && (r_acc ^ ODD));
endmodule

// File: tb/tb_parity_serializer.sv
// tb_parity_serializer: randomized frames checked cycle by cycle against an arithmetic frame model
module tb_parity_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [5:0] got_a, got_b, got_c, exp_a, exp_b, exp_c;
  always #5 clk = ~clk;
  parity_serializer_if #(.N(8)) a_if ();
  parity_serializer_if #(.N(8)) b_if ();
  parity_serializer_if #(.N(1)) c_if ();
  parity_serializer #(.N(8), .ODD(1'b0)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  parity_serializer #(.N(8), .ODD(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  parity_serializer #(.N(1), .ODD(1'b0)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if));
  // Output vectors: {ser_valid, busy, ser_is_par, ser_last, in_ready, ser_out}
  always_comb begin
    got_a = {a_if.ser_valid, a_if.busy, a_if.ser_is_par, a_if.ser_last, a_if.in_ready, a_if.ser_out};
    got_b = {b_if.ser_valid, b_if.busy, b_if.ser_is_par, b_if.ser_last, b_if.in_ready, b_if.ser_out};
    got_c = {c_if.ser_valid, c_if.busy, c_if.ser_is_par, c_if.ser_last, c_if.in_ready, c_if.ser_out};
  end
  task automatic drive8(input logic [7:0] d, input logic v);
    a_if.in_data = d;
    b_if.in_data = d;
    a_if.in_valid = v;
    b_if.in_valid = v;
  endtask
  // n words (1 or 2) sent back-to-back; scramble toggles in_data while it must be ignored
  task automatic run_frames(input string name, input logic [7:0] w0, input logic [7:0] w1,
                            input int n, input bit scramble);
    logic [7:0] ew;
    int j, i;
    @(negedge clk);
    checks++;
    if (got_a !== 6'b000010 || got_b !== 6'b000010) begin
      errors++;
      $display("FAIL %s_idle_pre: got a=%b b=%b want 000010", name, got_a, got_b);
    end
    drive8(w0, 1'b1);
    for (int c = 1; c <= n * 9; c++) begin
      @(negedge clk);
      j = (c - 1) / 9;
      i = (c - 1) % 9;
      ew = (j == 0) ? w0 : w1;
      exp_a = {1'b1, 1'b1, i == 8, i == 8, i == 8, (i < 8) ? ew[i] : ^ew};
      exp_b = {1'b1, 1'b1, i == 8, i == 8, i == 8, (i < 8) ? ew[i] : ~^ew};
      checks++;
      if (got_a !== exp_a) begin
        errors++;
        $display("FAIL %s_even word%0d bit%0d: got %b want %b", name, j, i, got_a, exp_a);
      end
      checks++;
      if (got_b !== exp_b) begin
        errors++;
        $display("FAIL %s_odd word%0d bit%0d: got %b want %b", name, j, i, got_b, exp_b);
      end
      drive8((i == 8 && j < n - 1) ? w1 : (scramble ? 8'($urandom) : a_if.in_data), j < n - 1);
    end
    @(negedge clk);
    checks++;
    if (got_a !== 6'b000010 || got_b !== 6'b000010) begin
      errors++;
      $display("FAIL %s_idle_post: got a=%b b=%b want 000010", name, got_a, got_b);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    drive8(8'h00, 1'b0);
    c_if.in_data = 1'b0;
    c_if.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (got_a !== 6'b0 || got_b !== 6'b0 || got_c !== 6'b0) begin
      errors++;
      $display("FAIL reset_hold: got a=%b b=%b c=%b want 000000", got_a, got_b, got_c);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (got_a !== 6'b000010 || got_b !== 6'b000010 || got_c !== 6'b000010) begin
      errors++;
      $display("FAIL reset_release: got a=%b b=%b c=%b want 000010", got_a, got_b, got_c);
    end
  endtask
  task automatic test_basic();
    run_frames("word101", 8'd101, 8'h00, 1, 1'b0);
    run_frames("wordFF", 8'hFF, 8'h00, 1, 1'b0);
    run_frames("word01", 8'h01, 8'h00, 1, 1'b0);
  endtask
  task automatic test_back_to_back();
    run_frames("b2b_A5_3C", 8'hA5, 8'h3C, 2, 1'b0);
  endtask
  task automatic test_busy_scramble();
    repeat (4) run_frames("scramble", 8'($urandom), 8'($urandom), 2, 1'b1);
  endtask
  task automatic test_random();
    repeat (8) run_frames("random", 8'($urandom), 8'($urandom), 1 + int'($urandom_range(1)), 1'($urandom));
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    drive8(8'hC3, 1'b1);
    @(negedge clk);
    drive8(8'hC3, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (got_a !== 6'b0 || got_b !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_drop: got a=%b b=%b want 000000", got_a, got_b);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (got_a !== 6'b0 || got_b !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: got a=%b b=%b want 000000", got_a, got_b);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (got_a !== 6'b000010 || got_b !== 6'b000010) begin
      errors++;
      $display("FAIL reset_mid_release: got a=%b b=%b want 000010", got_a, got_b);
    end
    run_frames("after_reset_80", 8'h80, 8'h00, 1, 1'b0);
  endtask
  task automatic test_n1();
    logic v [6];
    v[0] = 1'b1;
    v[1] = 1'b0;
    for (int k = 2; k < 6; k++) v[k] = 1'($urandom);
    @(negedge clk);
    checks++;
    if (got_c !== 6'b000010) begin
      errors++;
      $display("FAIL n1_idle_pre: got %b want 000010", got_c);
    end
    c_if.in_data = v[0];
    c_if.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_c = {5'b11000, v[k]};
      checks++;
      if (got_c !== exp_c) begin
        errors++;
        $display("FAIL n1_data%0d: got %b want %b", k, got_c, exp_c);
      end
      @(negedge clk);
      exp_c = {5'b11111, v[k] ^ 1'b0};
      checks++;
      if (got_c !== exp_c) begin
        errors++;
        $display("FAIL n1_par%0d: got %b want %b", k, got_c, exp_c);
      end
      c_if.in_data = (k < 5) ? v[k + 1] : 1'b0;
      c_if.in_valid = (k < 5);
    end
    @(negedge clk);
    checks++;
    if (got_c !== 6'b000010) begin
      errors++;
      $display("FAIL n1_idle_post: got %b want 000010", got_c);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_busy_scramble();
    test_random();
    test_reset_mid();
    test_n1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/parity_serializer.md
Name: parity_serializer

Overview:
Upstream feeder for the serial parity-tracking stage. Accepts an N-bit parallel word over a valid/ready handshake and shifts it out LSB-first, one bit per clock. It then appends one computed parity bit, so each frame is N+1 serial cycles. Downstream stages sample ser_out on posedge clk while ser_valid is high.

Parameters:
N, 8, data word width in bits (N >= 1).
ODD, 0, parity sense: 0 gives even parity (total ones in data plus parity bit is even); 1 gives odd parity.

Ports:
clk  input  1  single clock; all state changes on posedge.
rst_n  input  1  reset; asynchronous, active-low.
in_data  input  N  parallel word; sampled only on an accepting edge.
in_valid  input  1  upstream has a word on in_data.
in_ready  output  1  block can accept a word this cycle.
ser_out  output  1  current serial bit (data bit or parity bit).
ser_valid  output  1  ser_out carries a frame bit this cycle.
ser_is_par  output  1  current bit is the parity bit.
ser_last  output  1  current bit is the final bit of the frame (equals ser_is_par).
busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, shift register=0, bit counter=0, parity accumulator=0.
  - Outputs during reset: in_ready=0 while rst_n is low, then 1 after release; ser_out=0, ser_valid=0, ser_is_par=0, ser_last=0, busy=0.
- Outputs are Moore-style and derived from registered state only. There is no combinational path from in_valid or in_data to any output.
- States: IDLE, DATA, PAR.
- IDLE:
  - in_ready=1, ser_valid=0, ser_out=0.
  - Accept on a posedge with in_valid=1 and in_ready=1: shreg<=in_data, cnt<=0, acc<=0, go to DATA.
- DATA:
  - ser_valid=1, ser_out=shreg[0], in_ready=0.
  - Each posedge: acc<=acc^shreg[0], shreg<=shreg>>1, cnt<=cnt+1.
  - When cnt==N-1, go to PAR on that same edge.
  - The counter is ceil(log2(N)) bits, minimum 1 bit.
- PAR:
  - ser_valid=1, ser_is_par=1, ser_last=1, ser_out=acc^ODD, in_ready=1.
  - On the next posedge, if in_valid=1, accept the new word and go directly to DATA (back-to-back). Otherwise go to IDLE.
- Latency and throughput:
  - A word accepted at edge k produces data bit i during cycle k+1+i, for i = 0..N-1.
  - The parity bit appears during cycle k+N+1.
  - Sustained throughput is one word per N+1 cycles with no idle gap.
- in_data and in_valid are ignored while in_ready=0. Upstream must hold in_valid and in_data stable until accepted; no words are dropped or duplicated.
- N=1: frame is one data cycle followed by one parity cycle. The transition DATA->PAR happens on the first edge.
- Reset mid-frame: the frame is abandoned. ser_valid drops to 0 asynchronously, with no partial parity bit emitted. The next frame starts fresh from IDLE.
- No wrap-around: cnt never exceeds N-1, and shreg holds exactly N bits.

Test Plan:
1. Reset, N=8, ODD=0, in_data=8'd101 (0110_0101), in_valid pulse -> ser_out over 9 valid cycles = 1,0,1,0,0,1,1,0 then parity 0; ser_last high only in cycle 9.
2. Same word with ODD=1 -> identical data bits, parity bit 1; 8'hFF with ODD=0 gives parity 0; 8'h01 with ODD=0 gives parity 1.
3. Back-to-back: in_valid held high with 8'hA5 then 8'h3C -> 18 consecutive ser_valid cycles, no gap; second word is accepted on the edge ending the first parity cycle; parity bits 0 then 0.
4. in_data toggled randomly while busy, in_valid held -> serial stream is unaffected; the next word is accepted only when in_ready=1.
5. rst_n asserted low for 3 cycles in the middle of a frame (after bit 4) -> ser_valid and busy drop immediately; after release, in_ready=1 and a new word 8'h80 frames correctly with parity 1.
6. N=1, ODD=0: in_data=1 -> ser_out 1 then parity 1; in_data=0 -> ser_out 0 then parity 0; 2 cycles per frame.
